// File: rtl/lagged_correlator_bank.sv
// Lagged coincidence counter bank: every input pair (i<j) at every lag, plus per-input counts,
// integrated over a runtime window and streamed out of a shadow bank one word per handshake.
module lagged_correlator_bank #(
  parameter int NUM_INPUTS = 4,
  parameter int LAGS       = 4,
  parameter int RESOLUTION = 12,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] in,
  input  logic                  sample_pulse,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  integration_len,
  input  logic                  clear_overrun,
  output logic [RESOLUTION-1:0] out_data,
  output logic [15:0]           out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [15:0]           frame_count,
  output logic                  overrun
);

  localparam int NUM_PAIRS = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
  localparam int NUM_WORDS = NUM_PAIRS * LAGS + NUM_INPUTS;
  localparam int TAPS      = (LAGS > 1) ? LAGS - 1 : 1;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic {R_IDLE, R_STREAM} state_t;

  function automatic logic [RESOLUTION-1:0] sat_inc(input logic [RESOLUTION-1:0] v, input logic h);
    return (h && (v != '1)) ? v + RESOLUTION'(1) : v;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [TAPS-1:0]       r_tap    [NUM_INPUTS];
  logic [RESOLUTION-1:0] r_cnt    [NUM_WORDS];
  logic [RESOLUTION-1:0] r_shadow [NUM_WORDS];
  logic [RESOLUTION-1:0] w_next   [NUM_WORDS];
  logic [NUM_WORDS-1:0]  w_hit;
  logic [LEN_WIDTH-1:0]  r_win;
  logic [RESOLUTION-1:0] r_data;
  logic [15:0]           r_idx, r_frame, w_idx_nxt;
  logic                  r_ovr;
  logic                  w_step, w_win_end, w_accept, w_final, w_load, w_drop;

  // Word p*LAGS+k: pair p = (i,j) enumerated row-major over i<j; tap k-1 holds in[j] from k steps ago.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_i
    for (genvar gj = gi + 1; gj < NUM_INPUTS; gj++) begin : g_j
      localparam int P = gi * NUM_INPUTS - gi * (gi + 1) / 2 + (gj - gi - 1);
      for (genvar gk = 0; gk < LAGS; gk++) begin : g_k
        if (gk == 0) begin : g_lag0
          assign w_hit[P*LAGS] = in[gi] & in[gj];
        end else begin : g_lagn
          assign w_hit[P*LAGS+gk] = in[gi] & r_tap[gj][gk-1];
        end
      end
    end
    assign w_hit[NUM_PAIRS*LAGS+gi] = in[gi];
  end

  always_comb begin
    for (int w = 0; w < NUM_WORDS; w++) w_next[w] = sat_inc(r_cnt[w], w_hit[w]);
  end

  assign w_step    = sample_pulse & enable;
  assign w_win_end = w_step && (integration_len != '0) && ((r_win + LEN_ONE) == integration_len);
  assign w_accept  = (r_state == R_STREAM) && out_ready;
  assign w_final   = w_accept && (r_idx == 16'(NUM_WORDS - 1));
  assign w_idx_nxt = r_idx + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A window closing on the same edge as the final accept starts the next frame directly.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (w_win_end) begin
          w_load      = 1'b1;
          w_state_nxt = R_STREAM;
        end
      end
      R_STREAM: begin
        if (w_final) begin
          if (w_win_end) w_load = 1'b1;
          else           w_state_nxt = R_IDLE;
        end else if (w_win_end) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_INPUTS; c++) r_tap[c] <= '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
        r_cnt[w]    <= '0;
        r_shadow[w] <= '0;
      end
      r_win   <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_step) begin
        for (int c = 0; c < NUM_INPUTS; c++) begin
          r_tap[c][0] <= in[c];
          for (int t = 1; t < TAPS; t++) r_tap[c][t] <= r_tap[c][t-1];
        end
        r_win <= w_win_end ? '0 : r_win + LEN_ONE;
        for (int w = 0; w < NUM_WORDS; w++) r_cnt[w] <= w_win_end ? '0 : w_next[w];
      end
      if (w_load) begin
        for (int w = 0; w < NUM_WORDS; w++) r_shadow[w] <= w_next[w];
        r_data  <= w_next[0];
        r_idx   <= '0;
        r_frame <= r_frame + 16'd1;
      end else if (w_accept && !w_final) begin
        r_data <= r_shadow[w_idx_nxt[IDX_W-1:0]];
        r_idx  <= w_idx_nxt;
      end
      if (w_drop)             r_ovr <= 1'b1;
      else if (clear_overrun) r_ovr <= 1'b0;
    end
  end

  assign out_data    = r_data;
  assign out_index   = r_idx;
  assign out_valid   = (r_state == R_STREAM);
  assign out_last    = out_valid && (r_idx == 16'(NUM_WORDS - 1));
  assign frame_count = r_frame;
  assign overrun     = r_ovr;

endmodule
